// File: rtl/spi_tx_arbiter.sv
// Two-requester arbiter in front of an SPI byte master. Ownership is held for a
// whole CS transaction (up to the byte marked last), then released through IDLE.
module spi_tx_arbiter #(
  parameter int PRIO_MODE = 0
) (
  input  logic       clock,
  input  logic       reset_async,
  input  logic       req0_valid,
  input  logic [7:0] req0_byte,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_byte,
  input  logic       req1_last,
  output logic       req1_ready,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_byte,
  output logic       tx_clear_cs,
  output logic [1:0] grant,
  output logic       busy,
  output logic [1:0] fsm_state
);

  // Handshake: a byte moves on a rising edge where valid and ready are both
  // high. valid never depends on ready; ready may depend on the owner's state.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam bit FIXED_PRIO = (PRIO_MODE != 0);

  state_t state;
  logic   last_owner;
  logic   tie_to_req1;
  logic   done0;
  logic   done1;

  // Round-robin hands a tie to whoever did not own the previous transaction.
  assign tie_to_req1 = FIXED_PRIO || !last_owner;
  assign done0 = (state == GRANT0) && req0_valid && tx_ready && req0_last;
  assign done1 = (state == GRANT1) && req1_valid && tx_ready && req1_last;

  always_ff @(posedge clock or posedge reset_async) begin
    if (reset_async) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      grant      <= 2'b00;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid && req1_valid) begin
            busy <= 1'b1;
            if (tie_to_req1) begin
              state <= GRANT1;
              grant <= 2'b10;
            end else begin
              state <= GRANT0;
              grant <= 2'b01;
            end
          end else if (req0_valid) begin
            state <= GRANT0;
            grant <= 2'b01;
            busy  <= 1'b1;
          end else if (req1_valid) begin
            state <= GRANT1;
            grant <= 2'b10;
            busy  <= 1'b1;
          end
        end
        GRANT0: begin
          if (done0) begin
            state      <= IDLE;
            last_owner <= 1'b0;
            grant      <= 2'b00;
            busy       <= 1'b0;
          end
        end
        GRANT1: begin
          if (done1) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            grant      <= 2'b00;
            busy       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Byte path is a plain mux selected by the registered owner.
  always_comb begin
    tx_valid    = 1'b0;
    tx_byte     = 8'h00;
    tx_clear_cs = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (state)
      GRANT0: begin
        tx_valid    = req0_valid;
        tx_byte     = req0_byte;
        tx_clear_cs = req0_last;
        req0_ready  = tx_ready;
      end
      GRANT1: begin
        tx_valid    = req1_valid;
        tx_byte     = req1_byte;
        tx_clear_cs = req1_last;
        req1_ready  = tx_ready;
      end
      default: begin
        tx_valid = 1'b0;
      end
    endcase
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Bench for spi_tx_arbiter: directed transaction scenarios plus random traffic,
// both PRIO_MODE settings checked every cycle against a transaction-level model.
module tb_spi_tx_arbiter;

  logic       clock;
  logic       reset_async;
  logic       req0_valid, req0_last, req1_valid, req1_last, tx_ready;
  logic [7:0] req0_byte, req1_byte;

  logic       req0_ready, req1_ready, tx_valid, tx_clear_cs, busy;
  logic [7:0] tx_byte;
  logic [1:0] grant, fsm_state;
  logic       req0_ready_p, req1_ready_p, tx_valid_p, tx_clear_cs_p, busy_p;
  logic [7:0] tx_byte_p;
  logic [1:0] grant_p, fsm_state_p;

  spi_tx_arbiter #(.PRIO_MODE(0)) dut_rr (
    .clock(clock), .reset_async(reset_async),
    .req0_valid(req0_valid), .req0_byte(req0_byte), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_byte(req1_byte), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_clear_cs(tx_clear_cs),
    .grant(grant), .busy(busy), .fsm_state(fsm_state)
  );

  spi_tx_arbiter #(.PRIO_MODE(1)) dut_fp (
    .clock(clock), .reset_async(reset_async),
    .req0_valid(req0_valid), .req0_byte(req0_byte), .req0_last(req0_last), .req0_ready(req0_ready_p),
    .req1_valid(req1_valid), .req1_byte(req1_byte), .req1_last(req1_last), .req1_ready(req1_ready_p),
    .tx_ready(tx_ready), .tx_valid(tx_valid_p), .tx_byte(tx_byte_p), .tx_clear_cs(tx_clear_cs_p),
    .grant(grant_p), .busy(busy_p), .fsm_state(fsm_state_p)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;

  // model: owner per instance (-1 none, 0 req0, 1 req1) and previous owner
  int own[2];
  int prev_owner[2];

  // scoreboard for round-robin instance transfers: {grant, last, byte}
  logic [10:0] exp_q[$];
  logic [10:0] log_q[$];

  // negedge snapshot of the round-robin instance for directed checks
  logic [1:0] s_grant, s_grant_p;
  logic       s_tv, s_r0, s_r1, s_r0_p, s_busy, pre_tv;
  logic [7:0] s_tb;
  bit         acc0, acc1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      own[i] = -1;
      prev_owner[i] = 1;
    end
  endtask

  // One clock edge of the arbitration rules, instance 1 is fixed priority.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (own[i] < 0) begin
        if (req0_valid && req1_valid) own[i] = (i == 1) ? 1 : 1 - prev_owner[i];
        else if (req0_valid) own[i] = 0;
        else if (req1_valid) own[i] = 1;
      end else begin
        logic v, l;
        v = (own[i] == 0) ? req0_valid : req1_valid;
        l = (own[i] == 0) ? req0_last : req1_last;
        if (v && tx_ready && l) begin
          prev_owner[i] = own[i];
          own[i] = -1;
        end
      end
    end
  endtask

  task automatic compare_inst(input int i, input logic tv, input logic [7:0] tb, input logic tc,
                              input logic [1:0] g, input logic bz, input logic r0, input logic r1);
    logic       ev, ec;
    logic [7:0] eb;
    logic [1:0] eg;
    string      tag;
    tag = (i == 0) ? "rr" : "fp";
    ev = 1'b0; eb = 8'h00; ec = 1'b0; eg = 2'b00;
    if (own[i] == 0) begin ev = req0_valid; eb = req0_byte; ec = req0_last; eg = 2'b01; end
    if (own[i] == 1) begin ev = req1_valid; eb = req1_byte; ec = req1_last; eg = 2'b10; end
    chk({tag, "_tx_valid"}, tv, ev);
    chk({tag, "_tx_byte"}, tb, eb);
    chk({tag, "_tx_clear_cs"}, tc, ec);
    chk({tag, "_grant"}, g, eg);
    chk({tag, "_busy"}, bz, own[i] >= 0);
    chk({tag, "_req0_ready"}, r0, own[i] == 0 && tx_ready);
    chk({tag, "_req1_ready"}, r1, own[i] == 1 && tx_ready);
  endtask

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic cycle(input bit pulse);
    if (pulse) begin
      #1;
      pre_tv = tx_valid;
      reset_async = 1'b1;
      #1;
      model_reset();
      chk("rst_pulse_tx_valid", tx_valid, 0);
      chk("rst_pulse_grant", grant, 0);
      chk("rst_pulse_busy", busy, 0);
      chk("rst_pulse_fp_grant", grant_p, 0);
      #1 reset_async = 1'b0;
    end
    @(negedge clock);
    compare_inst(0, tx_valid, tx_byte, tx_clear_cs, grant, busy, req0_ready, req1_ready);
    compare_inst(1, tx_valid_p, tx_byte_p, tx_clear_cs_p, grant_p, busy_p, req0_ready_p, req1_ready_p);
    acc0 = own[0] == 0 && tx_ready && req0_valid;
    acc1 = own[0] == 1 && tx_ready && req1_valid;
    if (tx_valid && tx_ready) log_q.push_back({grant, tx_clear_cs, tx_byte});
    s_grant = grant; s_grant_p = grant_p; s_tv = tx_valid; s_tb = tx_byte;
    s_r0 = req0_ready; s_r1 = req1_ready; s_r0_p = req0_ready_p; s_busy = busy;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v0, input logic [7:0] b0, input logic l0,
                       input logic v1, input logic [7:0] b1, input logic l1, input logic tr);
    req0_valid = v0; req0_byte = b0; req0_last = l0;
    req1_valid = v1; req1_byte = b1; req1_last = l1;
    tx_ready = tr;
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, log_q.size(), exp_q.size());
    while (exp_q.size() > 0 && log_q.size() > 0) chk({name, "_xfer"}, log_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    log_q.delete();
  endtask

  initial begin
    logic [1:0] rr_seq[8];
    int rem[2];
    logic [7:0] nb[2];

    reset_async = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    chk("reset_tx_valid", tx_valid, 0);
    chk("reset_grant", grant, 0);
    chk("reset_busy", busy, 0);
    chk("reset_req0_ready", req0_ready, 0);
    @(posedge clock);
    #1 reset_async = 1'b0;

    // 3-byte transaction from req0 with tx_ready pulsed
    drive(1, 8'h26, 0, 0, 0, 0, 0); cycle(0);
    chk("t034_idle_grant", s_grant, 2'b00);
    drive(1, 8'h26, 0, 0, 0, 0, 1); cycle(0);
    chk("t034_grant", s_grant, 2'b01);
    drive(1, 8'h11, 0, 0, 0, 0, 0); cycle(0);
    drive(1, 8'h11, 0, 0, 0, 0, 1); cycle(0);
    drive(1, 8'h22, 1, 0, 0, 0, 1); cycle(0);
    drive(0, 0, 0, 0, 0, 0, 0); cycle(0);
    chk("t034_idle_after", s_grant, 2'b00);
    exp_q.push_back({2'b01, 1'b0, 8'h26});
    exp_q.push_back({2'b01, 1'b0, 8'h11});
    exp_q.push_back({2'b01, 1'b1, 8'h22});
    check_log("t034");

    // both requesting single-byte transactions from a fresh reset
    cycle(1);
    rr_seq = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    for (int c = 0; c < 8; c++) begin
      drive(1, 8'hA0, 1, 1, 8'hB1, 1, 1); cycle(0);
      chk("t035_rr_grant", s_grant, rr_seq[c]);
      chk("t036_fp_grant", s_grant_p, (c % 2 == 1) ? 2'b10 : 2'b00);
      chk("t036_fp_req0_ready", s_r0_p, 0);
    end
    log_q.delete();

    // req0 gap mid-transaction while req1 waits
    drive(1, 8'h40, 0, 1, 8'h55, 1, 1); cycle(0);
    drive(1, 8'h40, 0, 1, 8'h55, 1, 1); cycle(0);
    chk("t037_owner", s_grant, 2'b01);
    for (int c = 0; c < 5; c++) begin
      drive(0, 8'h00, 0, 1, 8'h55, 1, 1); cycle(0);
      chk("t037_gap_grant", s_grant, 2'b01);
      chk("t037_gap_req1_ready", s_r1, 0);
      chk("t037_gap_tx_valid", s_tv, 0);
    end
    drive(1, 8'h41, 1, 1, 8'h55, 1, 1); cycle(0);
    drive(0, 8'h00, 0, 1, 8'h55, 1, 1); cycle(0);
    chk("t037_dead_cycle", s_grant, 2'b00);
    drive(0, 8'h00, 0, 1, 8'h55, 1, 1); cycle(0);
    chk("t037_req1_after", s_grant, 2'b10);
    exp_q.push_back({2'b01, 1'b0, 8'h40});
    exp_q.push_back({2'b01, 1'b1, 8'h41});
    exp_q.push_back({2'b10, 1'b1, 8'h55});
    check_log("t037");

    // tx_ready stalled in GRANT0
    drive(1, 8'h77, 1, 0, 0, 0, 0); cycle(0);
    for (int c = 0; c < 10; c++) begin
      drive(1, 8'h77, 1, 0, 0, 0, 0); cycle(0);
      chk("t039_stall_grant", s_grant, 2'b01);
      chk("t039_stall_byte", s_tb, 8'h77);
      chk("t039_stall_ready", s_r0, 0);
    end
    chk("t039_no_xfer", log_q.size(), 0);
    drive(1, 8'h77, 1, 0, 0, 0, 1); cycle(0);
    drive(0, 0, 0, 0, 0, 0, 0); cycle(0);
    chk("t039_idle_after", s_grant, 2'b00);
    exp_q.push_back({2'b01, 1'b1, 8'h77});
    check_log("t039");

    // reset between edges during GRANT1 after 2 of 4 bytes
    drive(0, 0, 0, 1, 8'hC1, 0, 1); cycle(0);
    drive(0, 0, 0, 1, 8'hC1, 0, 1); cycle(0);
    drive(0, 0, 0, 1, 8'hC2, 0, 1); cycle(0);
    drive(1, 8'h5A, 1, 1, 8'hC3, 0, 1); cycle(1);
    chk("t038_pre_tx_valid", pre_tv, 1);
    chk("t038_post_grant", s_grant, 2'b00);
    drive(1, 8'h5A, 1, 1, 8'hC3, 0, 1); cycle(0);
    chk("t038_req0_first", s_grant, 2'b01);
    drive(0, 0, 0, 0, 0, 0, 0); cycle(0);
    exp_q.push_back({2'b10, 1'b0, 8'hC1});
    exp_q.push_back({2'b10, 1'b0, 8'hC2});
    exp_q.push_back({2'b01, 1'b1, 8'h5A});
    check_log("t038");

    // random traffic
    rem = '{0, 0};
    nb = '{8'h00, 8'h00};
    acc0 = 0; acc1 = 0;
    for (int c = 0; c < 3000; c++) begin
      bit pulse;
      if (acc0) begin rem[0]--; nb[0] = 8'($urandom); end
      if (acc1) begin rem[1]--; nb[1] = 8'($urandom); end
      for (int n = 0; n < 2; n++)
        if (rem[n] == 0 && $urandom_range(0, 2) == 0) begin
          rem[n] = $urandom_range(1, 4);
          nb[n] = 8'($urandom);
        end
      pulse = ($urandom_range(0, 299) == 0);
      drive(rem[0] > 0 && $urandom_range(0, 3) != 0, nb[0], rem[0] == 1,
            rem[1] > 0 && $urandom_range(0, 3) != 0, nb[1], rem[1] == 1,
            $urandom_range(0, 9) < 7);
      cycle(pulse);
      if (pulse) begin
        rem = '{0, 0};
        acc0 = 0; acc1 = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
